// File: rtl/ad2tx_pkg.sv
// Shared defaults and sizing helpers for the AD-to-TX sample FIFO.
package ad2tx_pkg;

    localparam int DW_DEF       = 8;
    localparam int AW_DEF       = 11;
    localparam int AFULL_TH_DEF = 2032;

    // Output skid stage entries; the prefetch logic keeps skid + in-flight read within this.
    localparam int SKID_DEPTH = 2;

    function automatic int depth(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/ad2tx_sdpram.sv
// Simple dual-port RAM, one write and one read port, registered read data, no output reset.
module ad2tx_sdpram #(
    parameter int DW = 8,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/ad2tx_fifo.sv
// First-word-fall-through FIFO between the AD sample path and the TX framer:
// block-RAM storage, prefetch into a 2-entry skid stage, level/flag tracking and flush.
module ad2tx_fifo
    import ad2tx_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int AFULL_TH = AFULL_TH_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          almost_full,
    output logic          overflow,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          rd_ready,
    output logic [AW:0]   level
);

    localparam int          DEPTH     = depth(AW);
    localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL_TH);

    logic [AW-1:0]                  wptr;
    logic [AW-1:0]                  rptr;
    logic                           rd_pend;
    logic [SKID_DEPTH-1:0]          sk_vld;
    logic [SKID_DEPTH-1:0][DW-1:0]  sk_dat;
    logic [SKID_DEPTH-1:0]          sk_vld_n;
    logic [SKID_DEPTH-1:0][DW-1:0]  sk_dat_n;
    logic [DW-1:0]                  ram_q;

    logic          wr_acc;
    logic          xfer;
    logic          rd_issue;
    logic [2:0]    pipe_occ;
    logic [AW:0]   ram_cnt;
    logic [AW:0]   level_nxt;

    assign wr_acc    = wr_en && !full && !clr;
    assign xfer      = sk_vld[0] && rd_ready;
    assign pipe_occ  = 3'(sk_vld[0]) + 3'(sk_vld[1]) + 3'(rd_pend);
    // Words still sitting in RAM, not yet read out; level counts them plus the pipeline.
    assign ram_cnt   = level - (AW+1)'(pipe_occ);
    assign rd_issue  = !clr && (ram_cnt != '0) && ((pipe_occ - 3'(xfer)) < 3'(SKID_DEPTH));
    assign level_nxt = level + (AW+1)'(wr_acc) - (AW+1)'(xfer);

    assign dout       = sk_dat[0];
    assign dout_valid = sk_vld[0];

    ad2tx_sdpram #(.DW(DW), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wptr),
        .wdata (din),
        .re    (rd_issue),
        .raddr (rptr),
        .rdata (ram_q)
    );

    // Pop head on transfer first, then land the returning read in the lowest free slot.
    always_comb begin
        sk_vld_n = sk_vld;
        sk_dat_n = sk_dat;
        if (xfer) begin
            sk_vld_n    = {1'b0, sk_vld[1]};
            sk_dat_n[0] = sk_dat[1];
        end
        if (rd_pend) begin
            if (!sk_vld_n[0]) begin
                sk_vld_n[0] = 1'b1;
                sk_dat_n[0] = ram_q;
            end else begin
                sk_vld_n[1] = 1'b1;
                sk_dat_n[1] = ram_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            level       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            rd_pend     <= 1'b0;
            sk_vld      <= '0;
            sk_dat      <= '0;
        end else if (clr) begin
            wptr        <= '0;
            rptr        <= '0;
            level       <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            rd_pend     <= 1'b0;
            sk_vld      <= '0;
        end else begin
            if (wr_acc)
                wptr <= wptr + AW'(1);
            if (rd_issue)
                rptr <= rptr + AW'(1);
            if (wr_en && full)
                overflow <= 1'b1;
            rd_pend     <= rd_issue;
            level       <= level_nxt;
            full        <= (level_nxt == DEPTH_LVL);
            almost_full <= (level_nxt >= AFULL_LVL);
            sk_vld      <= sk_vld_n;
            sk_dat      <= sk_dat_n;
        end
    end

endmodule

// File: doc/ad2tx_fifo.md
Name: ad2tx_fifo

Overview:
- Parametrised single-clock FIFO between the AD sample path and the TX framer; generalises the fixed 2048x8 simple-dual-port buffer.
- Adds occupancy tracking, full/almost-full flags and a sticky overflow flag.
- Adds a first-word-fall-through output with valid/ready, and a synchronous flush.
- Storage is an inferred simple-dual-port block RAM with registered read, plus a 2-entry output skid stage.

Parameters:
- DW, 8, data width in bits.
- AW, 11, address width; DEPTH = 2**AW words of capacity (2048).
- AFULL_TH, 2032, almost_full asserts when level >= AFULL_TH; legal range 1..DEPTH.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous flush; empties the FIFO and clears overflow.
- wr_en  input  1  write request.
- din  input  DW  write data.
- full  output  1  level == DEPTH.
- almost_full  output  1  level >= AFULL_TH.
- overflow  output  1  sticky; set by a write attempt while full.
- dout  output  DW  head-of-queue data, valid when dout_valid = 1.
- dout_valid  output  1  head word present.
- rd_ready  input  1  consumer accepts dout; a transfer occurs when dout_valid && rd_ready.
- level  output  AW+1  words accepted and not yet delivered, 0..DEPTH.

Behaviour:
- Reset (async assert, sync deassert upstream): all pointers, level, full, almost_full, overflow, dout_valid and dout = 0; skid stage empty; RAM contents undefined.
- Write accept: wr_en && !full && !clr at an edge stores din at wptr; wptr wraps modulo DEPTH.
- Write while full: data dropped, no state change except overflow <= 1.
- Level update: +1 per accepted write, -1 per output transfer; both in the same cycle leaves level unchanged.
- Flags: full and almost_full are registered, derived from next-level, so they are valid in the same cycle as level.
- Capacity: exactly DEPTH words, counting RAM, the in-flight read and the skid stage together.
- Prefetch: issue a RAM read when RAM holds unread words and the skid stage plus the in-flight read will have a free slot after this cycle's transfer. Read data lands in the skid stage one cycle after issue.
- dout and dout_valid come from skid entry 0 (registered); entry 1 shifts into entry 0 on a transfer.
- Throughput: sustains 1 word/clk with rd_ready held high and continuous writes.
- Latency: a word written at edge k into an empty FIFO gives dout_valid = 1 after edge k+2.
- Read/write collision: a RAM read and write to the same address in the same cycle cannot occur, because reads only target committed words.
- dout is stable while dout_valid && !rd_ready.
- Wrap-around: pointers are AW bits; level disambiguates full vs empty.
- clr (priority over wr_en and transfers): next edge forces pointers, level and flags to 0, dout_valid to 0 and the skid stage empty; any in-flight read is discarded.
- Simultaneous full write and read: the write is still rejected, because full is registered. The read completes, and full deasserts the next cycle.
- Reset mid-burst: immediate empty state; no partial word is ever presented.

Decomposition:
- Package ad2tx_pkg: default DW/AW/AFULL_TH constants, a function for DEPTH, and the skid-stage depth constant (2).
- Sub-module ad2tx_sdpram: parametrised DW x 2**AW simple dual-port RAM, one write port and one read port, 1-cycle registered read, no output reset. It is inferred so it maps to a single block RAM at defaults.
- The top level holds pointers, level counter, flags and skid logic.

Test Plan:
- Reset then idle: level = 0, full = 0, almost_full = 0, overflow = 0, dout_valid = 0 for 10 cycles.
- Write 0x5A at edge k into empty FIFO, rd_ready = 0 -> dout_valid = 1, dout = 0x5A after edge k+2, level = 1. Assert rd_ready -> level = 0 and dout_valid = 0 next cycle.
- Stream 0x00..0xFF continuously with rd_ready = 1 -> in-order output, 1 word/clk after the 2-cycle fill, level never above 3.
- Fill 2048 words with rd_ready = 0 -> almost_full asserts at level 2032, full at 2048. A 2049th write sets overflow = 1 and level stays 2048. Drain all -> values in order, wrap correct.
- At full, assert wr_en and rd_ready together -> write dropped, overflow = 1, level = 2047, full = 0 next cycle.
- Mid-stream clr with 100 words queued and a read in flight -> next cycle level = 0, dout_valid = 0, overflow = 0. A subsequent write 0xA5 appears as the first output.
